// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline latch.
// Owns the PC and issues instruction reads. Returned words are latched with
// their PC+4 for decode. Jumps, branches and JR resolved in decode redirect
// the PC with a one-bubble penalty. A retired halt stops fetch until reset.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic [1:0]  pc_sel,
  input  logic        halt,
  input  logic [31:0] rs_data,
  output logic [31:0] instr_id,
  output logic [31:0] npc_id,
  output logic        valid_id,
  output logic        halted
);

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_REG    = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_BRANCH = 2'b11
  } pc_sel_e;

  logic [31:0] r_pc;
  logic [31:0] r_instr_id;
  logic [31:0] r_npc_id;
  logic        r_valid_id;
  logic        r_halted;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_tgt;
  logic [31:0] w_branch_off;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_redirect_tgt;
  pc_sel_e     w_sel;

  assign w_sel        = pc_sel_e'(pc_sel);
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_jump_tgt   = {r_npc_id[31:28], r_instr_id[25:0], 2'b00};
  assign w_branch_off = {{14{r_instr_id[15]}}, r_instr_id[15:0], 2'b00};
  assign w_branch_tgt = r_npc_id + w_branch_off;

  // Select the redirect target requested by the instruction in decode.
  always_comb begin
    // NOTE: default assigned first so every path drives the output; no latch.
    w_redirect_tgt = w_pc_plus4;
    case (w_sel)
      SEL_REG:    w_redirect_tgt = rs_data;
      SEL_JUMP:   w_redirect_tgt = w_jump_tgt;
      SEL_BRANCH: w_redirect_tgt = w_branch_tgt;
      default:    w_redirect_tgt = w_pc_plus4;
    endcase
  end

  // PC and IF/ID latch update, in strict priority order.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (RST) begin
      r_pc       <= PC_INIT;
      r_instr_id <= 32'd0;
      r_npc_id   <= 32'd0;
      r_valid_id <= 1'b0;
      r_halted   <= 1'b0;
    end else if (r_halted) begin
      r_valid_id <= 1'b0;
    end else if (stall) begin
      // Hold everything; a word returned this cycle is refetched later.
    end else if (r_valid_id && halt) begin
      r_halted   <= 1'b1;
      r_valid_id <= 1'b0;
    end else if (r_valid_id && (w_sel != SEL_SEQ)) begin
      // Wrong-path word fetched this cycle is dropped; no delay slot.
      r_pc       <= w_redirect_tgt;
      r_instr_id <= 32'd0;
      r_valid_id <= 1'b0;
    end else if (ihit) begin
      r_instr_id <= imemload;
      r_npc_id   <= w_pc_plus4;
      r_valid_id <= 1'b1;
      r_pc       <= w_pc_plus4;
    end else begin
      r_valid_id <= 1'b0;
    end
  end

  assign imemaddr = r_pc;
  assign imemREN  = ~r_halted;
  assign instr_id = r_instr_id;
  assign npc_id   = r_npc_id;
  assign valid_id = r_valid_id;
  assign halted   = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage. Each table row is one clock
// edge: the inputs to hold before the edge and the outputs expected after it.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, halt;
  logic [31:0] imemload, rs_data;
  logic [1:0]  pc_sel;
  logic        imemREN, valid_id, halted;
  logic [31:0] imemaddr, instr_id, npc_id;

  int n_vec = 0;
  int n_bad = 0;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .pc_sel(pc_sel), .halt(halt), .rs_data(rs_data),
    .instr_id(instr_id), .npc_id(npc_id), .valid_id(valid_id),
    .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        stall;
    logic        ihit;
    logic [31:0] load;
    logic [1:0]  sel;
    logic        halt;
    logic [31:0] rs;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_npc;
    logic        e_valid;
    logic        e_halted;
    logic        e_ren;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic st, input logic ih, input logic [31:0] ld,
                              input logic [1:0] sl, input logic hl, input logic [31:0] rs,
                              input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] en, input logic ev, input logic eh);
    vec_t v;
    v.stall = st; v.ihit = ih; v.load = ld; v.sel = sl; v.halt = hl; v.rs = rs;
    v.e_addr = ea; v.e_instr = ei; v.e_npc = en; v.e_valid = ev;
    v.e_halted = eh; v.e_ren = ~eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] ea, input logic [31:0] ei,
                       input logic [31:0] en, input logic ev, input logic eh, input logic er);
    n_vec++;
    if (imemaddr !== ea || instr_id !== ei || npc_id !== en ||
        valid_id !== ev || halted !== eh || imemREN !== er) begin
      n_bad++;
      $display("FAIL %s: got addr=%h instr=%h npc=%h valid=%b halted=%b ren=%b, want addr=%h instr=%h npc=%h valid=%b halted=%b ren=%b",
               name, imemaddr, instr_id, npc_id, valid_id, halted, imemREN,
               ea, ei, en, ev, eh, er);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic ih, input logic [31:0] ld,
                       input logic [1:0] sl, input logic hl, input logic [31:0] rs);
    RST = rst; stall = st; ihit = ih; imemload = ld; pc_sel = sl; halt = hl; rs_data = rs;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //            stall ihit load          sel    halt rs            addr          instr         npc           v     h
    tbl[0]  = mk(1'b0, 1'b1, 32'h2001_0005, 2'b00, 1'b0, 32'h0,        32'h0000_0004, 32'h2001_0005, 32'h0000_0004, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 32'h2002_0007, 2'b00, 1'b0, 32'h0,        32'h0000_0008, 32'h2002_0007, 32'h0000_0008, 1'b1, 1'b0);
    // Three wait states at pc=8, then acceptance.
    tbl[2]  = mk(1'b0, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0,        32'h0000_0008, 32'h2002_0007, 32'h0000_0008, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0,        32'h0000_0008, 32'h2002_0007, 32'h0000_0008, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0,        32'h0000_0008, 32'h2002_0007, 32'h0000_0008, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 32'hAAAA_0001, 2'b00, 1'b0, 32'h0,        32'h0000_000C, 32'hAAAA_0001, 32'h0000_000C, 1'b1, 1'b0);
    // JR to 0x1C; word fetched the same cycle is discarded.
    tbl[6]  = mk(1'b0, 1'b1, 32'hDEAD_0000, 2'b01, 1'b0, 32'h0000_001C, 32'h0000_001C, 32'h0,        32'h0000_000C, 1'b0, 1'b0);
    // pc_sel ignored while valid_id=0.
    tbl[7]  = mk(1'b0, 1'b1, 32'h1000_FFFE, 2'b10, 1'b0, 32'h0,        32'h0000_0020, 32'h1000_FFFE, 32'h0000_0020, 1'b1, 1'b0);
    // Branch: 0x20 + (-2<<2) = 0x18.
    tbl[8]  = mk(1'b0, 1'b1, 32'hBAD0_0000, 2'b11, 1'b0, 32'h0,        32'h0000_0018, 32'h0,        32'h0000_0020, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 32'h0000_0008, 2'b00, 1'b0, 32'h0,        32'h0000_001C, 32'h0000_0008, 32'h0000_001C, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 32'hBAD0_0001, 2'b01, 1'b0, 32'h4000_000C, 32'h4000_000C, 32'h0,        32'h0000_001C, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 32'h0800_0040, 2'b00, 1'b0, 32'h0,        32'h4000_0010, 32'h0800_0040, 32'h4000_0010, 1'b1, 1'b0);
    // Jump: {4'h4, 26'h40, 2'b00} = 0x4000_0100.
    tbl[12] = mk(1'b0, 1'b1, 32'hBAD0_0002, 2'b10, 1'b0, 32'h0,        32'h4000_0100, 32'h0,        32'h4000_0010, 1'b0, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 32'h0C00_0001, 2'b00, 1'b0, 32'h0,        32'h4000_0104, 32'h0C00_0001, 32'h4000_0104, 1'b1, 1'b0);
    // Stall beats redirect for two cycles, then the jump to 0x4000_0004.
    tbl[14] = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0,        32'h4000_0104, 32'h0C00_0001, 32'h4000_0104, 1'b1, 1'b0);
    tbl[15] = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0,        32'h4000_0104, 32'h0C00_0001, 32'h4000_0104, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 1'b1, 32'hFFFF_FFFF, 2'b10, 1'b0, 32'h0,        32'h4000_0004, 32'h0,        32'h4000_0104, 1'b0, 1'b0);
    tbl[17] = mk(1'b0, 1'b1, 32'h0000_0008, 2'b00, 1'b0, 32'h0,        32'h4000_0008, 32'h0000_0008, 32'h4000_0008, 1'b1, 1'b0);
    // JR to the top word, then PC+4 wraps to 0.
    tbl[18] = mk(1'b0, 1'b1, 32'hBAD0_0003, 2'b01, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,        32'h4000_0008, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, 1'b1, 32'h0000_000D, 2'b00, 1'b0, 32'h0,        32'h0000_0000, 32'h0000_000D, 32'h0000_0000, 1'b1, 1'b0);
    // Halt in decode outranks the simultaneous jump request.
    tbl[20] = mk(1'b0, 1'b1, 32'h1111_1111, 2'b10, 1'b1, 32'h0,        32'h0000_0000, 32'h0000_000D, 32'h0000_0000, 1'b0, 1'b1);

    // Reset.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    check("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < NV; i++) begin
      drive(1'b0, tbl[i].stall, tbl[i].ihit, tbl[i].load, tbl[i].sel, tbl[i].halt, tbl[i].rs);
      check($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_instr, tbl[i].e_npc,
            tbl[i].e_valid, tbl[i].e_halted, tbl[i].e_ren);
    end

    // Halted: frozen for 10 cycles whatever the inputs do.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, i[0], 1'b1, 32'h2222_0000 + i, 2'(i), i[1], 32'h0000_0ABC);
      check($sformatf("halted%0d", i), 32'h0, 32'h0000_000D, 32'h0, 1'b0, 1'b1, 1'b0);
    end

    // Reset while halted.
    drive(1'b1, 1'b0, 1'b1, 32'h3333_3333, 2'b10, 1'b1, 32'h0);
    check("reset_halted", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Fetch once, then reset while stalled with a redirect pending.
    drive(1'b0, 1'b0, 1'b1, 32'h0800_0010, 2'b00, 1'b0, 32'h0);
    check("refetch", 32'h4, 32'h0800_0010, 32'h4, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h4444_4444, 2'b10, 1'b0, 32'h0);
    check("reset_stall", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
